// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges hazard stalls, ID branch flushes and MEM wait states into per-stage enables.
// Latency: zero (Mealy outputs); state and perf counters update on the rising edge. Optional counters: STALL_PERF_EN.
// Backpressure: a pending data-memory access freezes PC..EX/MEM and drains a bubble into WB; timeout parks in ERR.
module pipeline_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             branch_taken_ID,
    input  logic             dmem_req_EXMEM,
    input  logic             dmem_ready,
    output logic             pcWrite,
    output logic             write_IFID,
    output logic             flush_IFID,
    output logic             mux_IDEX,
    output logic             write_IDEX,
    output logic             write_EXMEM,
    output logic             write_MEMWB,
    output logic             bubble_MEMWB,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       rst_q;
    logic       mwait;

    assign mwait = dmem_req_EXMEM & ~dmem_ready;

    // rst_q holds the block inert from reset assertion until the first edge after release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_q   <= 1'b1;
            state_q <= RUN;
            wcnt_q  <= 8'd0;
        end else begin
            rst_q   <= 1'b0;
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        pcWrite      = 1'b0;
        write_IFID   = 1'b0;
        flush_IFID   = 1'b0;
        mux_IDEX     = 1'b0;
        write_IDEX   = 1'b0;
        write_EXMEM  = 1'b0;
        write_MEMWB  = 1'b0;
        bubble_MEMWB = 1'b0;
        mem_timeout  = 1'b0;
        if (!rst_q) begin
            if (state_q == ERR) begin
                mem_timeout = 1'b1;
            end else if (mwait) begin
                write_MEMWB  = 1'b1;
                bubble_MEMWB = 1'b1;
                mux_IDEX     = 1'b1;
                if (state_q == RUN) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd1;
                end else if (wcnt_q == 8'(MAX_WAIT)) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end else begin
                pcWrite     = 1'b1;
                write_IFID  = 1'b1;
                mux_IDEX    = 1'b1;
                write_IDEX  = 1'b1;
                write_EXMEM = 1'b1;
                write_MEMWB = 1'b1;
                if (hazard_stall) begin
                    pcWrite    = 1'b0;
                    write_IFID = 1'b0;
                    mux_IDEX   = 1'b0;
                end else if (branch_taken_ID) begin
                    flush_IFID = 1'b1;
                end
                state_d = RUN;
                wcnt_d  = 8'd0;
            end
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!rst_q && !pcWrite && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_IFID && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomised + directed bench for pipeline_stall_ctrl against a freeze-length reference model.
module tb_pipeline_stall_ctrl;

    localparam int CW   = 6;
    localparam int MW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hz = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
    logic pcWrite, write_IFID, flush_IFID, mux_IDEX, write_IDEX, write_EXMEM, write_MEMWB;
    logic bubble_MEMWB, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    pipeline_stall_ctrl #(.CNT_W(CW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .hazard_stall(hz), .branch_taken_ID(br),
        .dmem_req_EXMEM(req), .dmem_ready(rdy), .pcWrite(pcWrite), .write_IFID(write_IFID),
        .flush_IFID(flush_IFID), .mux_IDEX(mux_IDEX), .write_IDEX(write_IDEX),
        .write_EXMEM(write_EXMEM), .write_MEMWB(write_MEMWB), .bubble_MEMWB(bubble_MEMWB),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: length of the current unbroken memory-wait run and a sticky error flag.
    bit in_rst = 1'b0;
    bit m_err = 1'b0;
    int frz = 0;
    int m_sc = 0, m_fc = 0;

    logic e_pc, e_ifid, e_fl, e_mux, e_idex, e_exmem, e_memwb, e_bub, e_to;

    always_comb begin
        e_pc = 0; e_ifid = 0; e_fl = 0; e_mux = 0; e_idex = 0;
        e_exmem = 0; e_memwb = 0; e_bub = 0; e_to = 0;
        if (!(reset || in_rst)) begin
            if (m_err) begin
                e_to = 1;
            end else if (req && !rdy) begin
                e_memwb = 1; e_bub = 1; e_mux = 1;
            end else begin
                e_pc = !hz; e_ifid = !hz; e_mux = !hz;
                e_idex = 1; e_exmem = 1; e_memwb = 1;
                e_fl = !hz && br;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            in_rst = 1; m_err = 0; frz = 0; m_sc = 0; m_fc = 0;
        end else if (in_rst) begin
            in_rst = 0;
        end else begin
`ifdef STALL_PERF_EN
            if (!e_pc && m_sc < MAXC) m_sc++;
            if (e_fl && m_fc < MAXC) m_fc++;
`endif
            if (!m_err) begin
                if (req && !rdy) begin
                    frz++;
                    if (frz == MW + 1) m_err = 1;
                end else begin
                    frz = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("pcWrite", int'(pcWrite), int'(e_pc));
            check("write_IFID", int'(write_IFID), int'(e_ifid));
            check("flush_IFID", int'(flush_IFID), int'(e_fl));
            check("mux_IDEX", int'(mux_IDEX), int'(e_mux));
            check("write_IDEX", int'(write_IDEX), int'(e_idex));
            check("write_EXMEM", int'(write_EXMEM), int'(e_exmem));
            check("write_MEMWB", int'(write_MEMWB), int'(e_memwb));
            check("bubble_MEMWB", int'(bubble_MEMWB), int'(e_bub));
            check("mem_timeout", int'(mem_timeout), int'(e_to));
            check("stall_cnt", int'(stall_cnt), m_sc);
            check("flush_cnt", int'(flush_cnt), m_fc);
        end
    end

    task automatic drive(input logic h, input logic b, input logic q, input logic r);
        @(posedge clk);
        #1;
        hz = h; br = b; req = q; rdy = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int err_cycles;
        int slow;
        #2 reset = 1'b1;
        #1 started = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("lit_rst_pc", int'(pcWrite), 0);
        check("lit_rst_memwb", int'(write_MEMWB), 0);
        reset = 1'b0;

        drive(0, 0, 0, 0);
        check("lit_idle_pc", int'(pcWrite), 1);
        check("lit_idle_mux", int'(mux_IDEX), 1);
        drive(1, 0, 0, 0);
        check("lit_hz_pc", int'(pcWrite), 0);
        check("lit_hz_mux", int'(mux_IDEX), 0);
        check("lit_hz_idex", int'(write_IDEX), 1);
        drive(0, 0, 0, 0);
        check("lit_hz_release", int'(pcWrite), 1);
        drive(1, 1, 0, 0);
        check("lit_hzbr_flush", int'(flush_IFID), 0);
        drive(0, 1, 0, 0);
        check("lit_br_flush", int'(flush_IFID), 1);
        drive(0, 0, 0, 0);
`ifdef STALL_PERF_EN
        check("lit_stall_cnt2", int'(stall_cnt), 2);
        check("lit_flush_cnt1", int'(flush_cnt), 1);
`else
        check("lit_stall_cnt0", int'(stall_cnt), 0);
`endif
        repeat (3) begin
            drive(0, 0, 1, 0);
            check("lit_frz_bub", int'(bubble_MEMWB), 1);
            check("lit_frz_exmem", int'(write_EXMEM), 0);
        end
        drive(0, 0, 1, 1);
        check("lit_ready_pc", int'(pcWrite), 1);
        check("lit_ready_bub", int'(bubble_MEMWB), 0);
        drive(0, 1, 1, 0);
        check("lit_brfrz_flush", int'(flush_IFID), 0);
        drive(0, 1, 0, 0);
        check("lit_brafter_flush", int'(flush_IFID), 1);
        repeat (MW + 1) begin
            drive(0, 0, 1, 0);
            check("lit_to_frz", int'(mem_timeout), 0);
        end
        drive(0, 0, 1, 0);
        check("lit_to_err", int'(mem_timeout), 1);
        check("lit_err_memwb", int'(write_MEMWB), 0);
        drive(0, 0, 0, 1);
        check("lit_err_sticky", int'(mem_timeout), 1);
        check("lit_err_pc", int'(pcWrite), 0);
        reset = 1'b1;
        #1;
        check("lit_arst_to", int'(mem_timeout), 0);
        check("lit_arst_cnt", int'(stall_cnt), 0);
        drive(0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0);
        check("lit_post_rst_pc", int'(pcWrite), 1);

        err_cycles = 0;
        slow = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i % 40 == 0) slow = ($urandom_range(0, 1) == 1) ? 1 : 0;
            @(posedge clk);
            #1;
            if (reset) reset = 1'b0;
            hz  = ($urandom_range(0, 99) < 20);
            br  = ($urandom_range(0, 99) < 25);
            req = ($urandom_range(0, 99) < (slow ? 80 : 35));
            rdy = ($urandom_range(0, 99) < (slow ? 10 : 60));
            err_cycles = m_err ? err_cycles + 1 : 0;
            if (err_cycles > 3 || $urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                err_cycles = 0;
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
